// File: rtl/nibble_feed_fifo_if.sv
// Producer/consumer bundle around the nibble feed FIFO; slave is the FIFO side.
// Carries control (flush) and status (count, overflow) alongside both stream handshakes.
interface nibble_feed_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, overflow
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/nibble_feed_fifo.sv
// FWFT operand FIFO feeding the 4-bit array block: push visible one edge later, no bypass.
// in_ready drops when full even if popping; pushes while full are dropped and flagged in overflow.
module nibble_feed_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  nibble_feed_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic [WIDTH-1:0] hold_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] out_data_c;

  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    push       = bus.in_valid & ~full;
    pop        = bus.out_ready & ~empty;
    head       = mem[rd_ptr];
    // Hold the last popped word while empty so the array input never sees X.
    out_data_c = empty ? hold_q : head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= out_data_c;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        hold_q <= head;
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (bus.in_valid && full) ovf_q <= 1'b1;
    end
  end

  // Storage is don't-care after reset; only entries behind a nonzero count are ever read.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = out_data_c;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: doc/nibble_feed_fifo.md
Name: nibble_feed_fifo

Overview:
- Buffered input stage that sits directly upstream of the 4-bit combinational array block (arr in, out out).
- Accepts a stream of WIDTH-bit operand words over a valid/ready handshake and stores them in a first-word-fall-through FIFO.
- Presents the head word on a stable output bus that drives the downstream block's arr input; the consumer pops words with out_ready.
- Replaces hand-driven testbench stimulus with a paced, back-pressured source.

Parameters:
- WIDTH, 4, data word width in bits; matches the downstream arr width.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low, asynchronous.
- flush  input  1  synchronous clear of the FIFO contents.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO can accept a word; equals (count < DEPTH); combinational from registered state.
- in_data  input  WIDTH  word to enqueue.
- out_valid  output  1  FIFO is non-empty; equals (count != 0).
- out_ready  input  1  consumer pops the head word this cycle.
- out_data  output  WIDTH  head word; feeds the downstream arr input.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: set when a push is attempted while the FIFO is full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Read and write pointers = 0; count = 0; out_valid = 0; out_data = 0; overflow = 0.
  - in_ready = 1 throughout reset.
  - Storage array contents are don't-care.
- Push: in_valid & in_ready at a clock edge writes in_data to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: out_valid & out_ready at a clock edge advances rd_ptr modulo DEPTH.
- Pointer wrap-around is natural binary wrap; DEPTH is a power of 2.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Latency: a word pushed at edge N into an empty FIFO appears at edge N with out_valid=1 visible after that edge. There is no same-cycle bypass of in_data to out_data.
- out_data:
  - When out_valid=1, out_data = mem[rd_ptr].
  - When out_valid=0, out_data holds the last popped word (0 if nothing has been popped since reset or flush), so the downstream arr input never sees X.
- Full (count=DEPTH):
  - in_ready=0, even if a pop occurs in the same cycle; there is no full-pop-push pass-through.
  - in_valid=1 while full sets overflow at that edge; the word is dropped.
- Empty (count=0): out_ready is ignored; no pointer change; out_data is held.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- flush=1 at an edge:
  - Pointers and count go to 0; overflow is cleared; out_data keeps its current value.
  - flush has priority over push and pop in the same cycle; both are discarded.
- overflow clears only on reset or flush.
- Reset asserted mid-stream: all state clears immediately, without waiting for clk; after rst_n deasserts, the first push is the first word out.
- Handshake rules:
  - The producer must hold in_data stable while in_valid=1 and in_ready=0.
  - The block never deasserts out_valid without a pop, flush or reset.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles → out_data=4'b0000, out_valid=0, in_ready=1, count=0, overflow=0; pulse rst_n low between clk edges → state clears asynchronously.
2. Single word: push 4'b0111 with out_ready=0 → next cycle out_valid=1, out_data=4'b0111, count=1; assert out_ready one cycle → out_valid=0, count=0, out_data stays 4'b0111.
3. Fill and overflow: push 4'h1, 4'h2, 4'h3, 4'h4, then offer 4'h5 → count=4, in_ready=0, overflow=1, 4'h5 dropped; pop all → order 1,2,3,4, then out_valid=0.
4. Wrap and streaming: push 4'hA..4'hF continuously with out_ready=1 from the cycle after the first push → count stays 1, outputs A..F in order across the pointer wrap, overflow=0.
5. Flush priority: count=3 with contents 4'h7, 4'h8, 4'h9; assert flush with in_valid=1 (4'hC) and out_ready=1 in the same cycle → count=0, overflow=0, out_valid=0, 4'hC not stored, out_data unchanged.
6. Full with simultaneous pop: count=4; in_valid=1 and out_ready=1 in the same cycle → pop occurs, push rejected, overflow=1, count=3.
